// File: rtl/tt_pkg.sv
// Shared types and default sizes for the run-time loadable truth table.
package tt_pkg;

    localparam int TT_ADDR_W = 3;
    localparam int TT_DATA_W = 2;

    // Load sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } tt_state_e;

endpackage : tt_pkg

// File: rtl/tt_mem.sv
// Table storage: register array cleared by reset, one synchronous write
// port and one combinational read port (same read timing as the ROM).
module tt_mem #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];

    // Entry storage: cleared on reset, one entry written per accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    // A read during the write cycle still sees the old entry.
    assign rdata = mem_reg[raddr];

endmodule : tt_mem

// File: rtl/tt_table_writer.sv
// Run-time loadable truth table: accepts DEPTH entries over a valid/ready
// stream in address order, then serves combinational reads like the ROM.
module tt_table_writer
    import tt_pkg::*;
#(
    parameter int ADDR_W = TT_ADDR_W,
    parameter int DATA_W = TT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    tt_state_e         state_reg;
    tt_state_e         state_next;
    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W-1:0] ptr_next;
    logic              err_reg;
    logic              err_next;
    logic              wr_en;

    // State, write pointer and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            err_reg   <= err_next;
        end
    end

    // Next-state, pointer and error logic; abort beats start and any beat.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        err_next   = err_reg;
        wr_en      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (abort) begin
                    ptr_next = '0;
                end else if (start) begin
                    state_next = LOAD;
                    ptr_next   = '0;
                    err_next   = 1'b0;
                end
            end
            LOAD: begin
                if (abort) begin
                    // Entries already written are kept; the pending beat is dropped.
                    state_next = IDLE;
                    ptr_next   = '0;
                end else if (in_valid) begin
                    wr_en    = 1'b1;
                    ptr_next = ptr_reg + PTR_ONE;
                    if (ptr_reg == LAST_PTR) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else if (start) begin
                    state_next = LOAD;
                    ptr_next   = '0;
                    err_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase

        // Data offered outside a load is flagged and discarded.
        if (in_valid && (state_reg != LOAD)) begin
            err_next = 1'b1;
        end
    end

    // Handshake and status outputs decoded purely from state.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_reg)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign err = err_reg;

    tt_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (ptr_reg),
        .wdata (in_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule : tt_table_writer
